// File: rtl/bemicro_cv_sys_clk_timer_master.sv
`default_nettype none
// ============================================================================
// Module      : bemicro_cv_sys_clk_timer_master
// Description : Avalon-MM initiator that programs a 16-bit-register interval
//               timer, runs it continuously and services every interrupt,
//               counting ticks. Optional snapshot readback is compiled in
//               with BEMICRO_CV_TIMER_SNAPSHOT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bemicro_cv_sys_clk_timer_master #(
    parameter int unsigned MIN_PERIOD = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_period,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    output logic        running,
    output logic        busy,
    output logic        tick,
    output logic [31:0] tick_count,
    output logic [31:0] snapshot,
    output logic [2:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    input  logic        irq
);

    localparam logic [3:0]  c_IDLE     = 4'd0;
    localparam logic [3:0]  c_WR_PL    = 4'd1;
    localparam logic [3:0]  c_WR_PH    = 4'd2;
    localparam logic [3:0]  c_WR_CTL   = 4'd3;
    localparam logic [3:0]  c_RUN      = 4'd4;
    localparam logic [3:0]  c_CLR_ST   = 4'd5;
`ifdef BEMICRO_CV_TIMER_SNAPSHOT_EN
    localparam logic [3:0]  c_SNAP_WR  = 4'd6;
    localparam logic [3:0]  c_RD_L     = 4'd7;
    localparam logic [3:0]  c_RD_LC    = 4'd8;
    localparam logic [3:0]  c_RD_H     = 4'd9;
    localparam logic [3:0]  c_RD_HC    = 4'd10;
`endif
    localparam logic [3:0]  c_WR_STOP  = 4'd11;

    localparam logic [2:0]  c_ADDR_STATUS = 3'd0;
    localparam logic [2:0]  c_ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  c_ADDR_PER_L  = 3'd2;
    localparam logic [2:0]  c_ADDR_PER_H  = 3'd3;
`ifdef BEMICRO_CV_TIMER_SNAPSHOT_EN
    localparam logic [2:0]  c_ADDR_SNAP_L = 3'd4;
    localparam logic [2:0]  c_ADDR_SNAP_H = 3'd5;
`endif
    localparam logic [15:0] c_CTL_RUN     = 16'h0007;  // START | CONT | ITO
    localparam logic [15:0] c_CTL_STOP    = 16'h0008;  // STOP, interrupts off
    localparam logic [31:0] c_MIN_PERIOD  = 32'(MIN_PERIOD);

    logic [3:0]  r_state;
    logic [3:0]  w_next_state;
    logic [31:0] r_period;
    logic        r_running;
    logic        r_stop_pend;
    logic [31:0] r_tick_count;
    logic [31:0] w_period_clamped;
    logic [2:0]  w_address;
    logic        w_chipselect;
    logic        w_write_n;
    logic [15:0] w_writedata;
    logic        w_tick;

    assign w_period_clamped = (cfg_period < c_MIN_PERIOD) ? c_MIN_PERIOD : cfg_period;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Bus outputs are decoded from state so reset idles the bus at once.
    always_comb begin
        w_next_state = r_state;
        w_address    = 3'd0;
        w_chipselect = 1'b0;
        w_write_n    = 1'b1;
        w_writedata  = 16'h0000;
        w_tick       = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (cfg_start) begin
                    w_next_state = c_WR_PL;
                end
            end
            c_WR_PL: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = c_ADDR_PER_L;
                w_writedata  = r_period[15:0];
                w_next_state = c_WR_PH;
            end
            c_WR_PH: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = c_ADDR_PER_H;
                w_writedata  = r_period[31:16];
                w_next_state = c_WR_CTL;
            end
            c_WR_CTL: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = c_ADDR_CTRL;
                w_writedata  = c_CTL_RUN;
                w_next_state = c_RUN;
            end
            c_RUN: begin
                if (irq) begin
                    w_next_state = c_CLR_ST;
                end else if (r_stop_pend) begin
                    w_next_state = c_WR_STOP;
                end
            end
            c_CLR_ST: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = c_ADDR_STATUS;
`ifdef BEMICRO_CV_TIMER_SNAPSHOT_EN
                w_next_state = c_SNAP_WR;
`else
                w_tick       = 1'b1;
                w_next_state = c_RUN;
`endif
            end
`ifdef BEMICRO_CV_TIMER_SNAPSHOT_EN
            c_SNAP_WR: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = c_ADDR_SNAP_L;
                w_next_state = c_RD_L;
            end
            c_RD_L: begin
                w_chipselect = 1'b1;
                w_address    = c_ADDR_SNAP_L;
                w_next_state = c_RD_LC;
            end
            c_RD_LC: begin
                w_chipselect = 1'b1;
                w_address    = c_ADDR_SNAP_L;
                w_next_state = c_RD_H;
            end
            c_RD_H: begin
                w_chipselect = 1'b1;
                w_address    = c_ADDR_SNAP_H;
                w_next_state = c_RD_HC;
            end
            c_RD_HC: begin
                w_chipselect = 1'b1;
                w_address    = c_ADDR_SNAP_H;
                w_tick       = 1'b1;
                w_next_state = c_RUN;
            end
`endif
            c_WR_STOP: begin
                w_chipselect = 1'b1;
                w_write_n    = 1'b0;
                w_address    = c_ADDR_CTRL;
                w_writedata  = c_CTL_STOP;
                w_next_state = c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_period     <= 32'h0;
            r_running    <= 1'b0;
            r_stop_pend  <= 1'b0;
            r_tick_count <= 32'h0;
        end else begin
            if ((r_state == c_IDLE) && cfg_start) begin
                r_period <= w_period_clamped;
            end
            if (r_state == c_WR_CTL) begin
                r_running <= 1'b1;
            end else if (r_state == c_WR_STOP) begin
                r_running <= 1'b0;
            end
            // A stop is remembered until the FSM is back in RUN to act on it.
            if (r_state == c_WR_STOP) begin
                r_stop_pend <= 1'b0;
            end else if (cfg_stop && (r_state != c_IDLE)) begin
                r_stop_pend <= 1'b1;
            end
            if (w_tick) begin
                r_tick_count <= r_tick_count + 32'd1;
            end
        end
    end

`ifdef BEMICRO_CV_TIMER_SNAPSHOT_EN
    logic [31:0] r_snapshot;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snapshot <= 32'h0;
        end else if (r_state == c_RD_LC) begin
            r_snapshot[15:0] <= readdata;
        end else if (r_state == c_RD_HC) begin
            r_snapshot[31:16] <= readdata;
        end
    end

    assign snapshot = r_snapshot;
`else
    logic w_unused_readdata;

    assign w_unused_readdata = ^readdata;
    assign snapshot          = 32'h0;
`endif

    assign running    = r_running;
    assign busy       = (r_state != c_IDLE) && (r_state != c_RUN);
    assign tick       = w_tick;
    assign tick_count = r_tick_count;
    assign address    = w_address;
    assign chipselect = w_chipselect;
    assign write_n    = w_write_n;
    assign writedata  = w_writedata;

endmodule
`default_nettype wire

// File: tb/tb_bemicro_cv_sys_clk_timer_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_bemicro_cv_sys_clk_timer_master
// Description : Bench for bemicro_cv_sys_clk_timer_master with a timer slave
//               model and a bus-write log compared against expected traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bemicro_cv_sys_clk_timer_master;

    localparam int unsigned MIN_P = 8;
`ifdef BEMICRO_CV_TIMER_SNAPSHOT_EN
    localparam bit SNAP = 1'b1;
`else
    localparam bit SNAP = 1'b0;
`endif
    localparam int unsigned SVC = SNAP ? 6 : 1;
    localparam logic [31:0] ANY = 32'hFFFF_FFFF;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [31:0] cfg_period = 32'h0;
    logic        cfg_start  = 1'b0;
    logic        cfg_stop   = 1'b0;
    logic        running;
    logic        busy;
    logic        tick;
    logic [31:0] tick_count;
    logic [31:0] snapshot;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata   = 16'h0;
    logic        irq;

    bemicro_cv_sys_clk_timer_master #(.MIN_PERIOD(MIN_P)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_period (cfg_period),
        .cfg_start  (cfg_start),
        .cfg_stop   (cfg_stop),
        .running    (running),
        .busy       (busy),
        .tick       (tick),
        .tick_count (tick_count),
        .snapshot   (snapshot),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Timer slave: status raised on request, cleared by writing address 0.
    logic        s_fire   = 1'b0;
    logic        s_status = 1'b0;
    logic [31:0] s_src    = 32'h0;
    logic [31:0] s_snap   = 32'h0;

    assign irq = s_status;

    always @(posedge clk) begin
        if (s_fire) s_status <= 1'b1;
        if (chipselect && !write_n) begin
            if (address == 3'd0) s_status <= 1'b0;
            if (address == 3'd4) s_snap <= s_src;
        end
        if (chipselect && write_n)
            readdata <= (address == 3'd4) ? s_snap[15:0] :
                        (address == 3'd5) ? s_snap[31:16] : 16'h0;
    end

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
        logic [31:0] c;
    } wr_t;

    wr_t         obs_q[$];
    wr_t         exp_q[$];
    int unsigned cyc         = 0;
    int unsigned tick_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (chipselect && !write_n) obs_q.push_back({address, writedata, 32'(cyc)});
            if (tick) tick_pulses <= tick_pulses + 1;
        end
    end

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_count = 32'h0;
    logic [31:0] m_snap  = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [2:0] a, input logic [15:0] d, input logic [31:0] c);
        exp_q.push_back({a, d, c});
    endtask

    task automatic cmp_bus(input string tag);
        chk({tag, "/nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            wr_t o;
            wr_t e;
            o = obs_q[i];
            e = exp_q[i];
            if (e.c == ANY) o.c = ANY;
            chk($sformatf("%s/wr%0d", tag, i), 64'(o), 64'(e));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "/running"},    64'(running),    64'(0));
        chk({tag, "/busy"},       64'(busy),       64'(0));
        chk({tag, "/tick"},       64'(tick),       64'(0));
        chk({tag, "/tick_count"}, 64'(tick_count), 64'(0));
        chk({tag, "/snapshot"},   64'(snapshot),   64'(0));
        chk({tag, "/bus"}, 64'({chipselect, write_n, address, writedata}), 64'({1'b0, 1'b1, 3'd0, 16'h0}));
    endtask

    task automatic do_start(input logic [31:0] p, input bit with_stop, input string tag);
        logic [31:0] pe;
        int unsigned c0;
        pe = (p < MIN_P) ? 32'(MIN_P) : p;
        c0 = cyc;
        cfg_period = p;
        cfg_start  = 1'b1;
        cfg_stop   = with_stop;
        exp_push(3'd2, pe[15:0],  c0 + 1);
        exp_push(3'd3, pe[31:16], c0 + 2);
        exp_push(3'd1, 16'h0007,  c0 + 3);
        step();
        cfg_start  = 1'b0;
        cfg_stop   = 1'b0;
        cfg_period = $urandom();
        step(2);
        chk({tag, "/running_c3"}, 64'(running), 64'(0));
        chk({tag, "/busy_c3"},    64'(busy),    64'(1));
        step();
        chk({tag, "/running_c4"}, 64'(running), 64'(1));
        chk({tag, "/busy_c4"},    64'(busy),    64'(0));
        cmp_bus(tag);
    endtask

    task automatic do_irq(input string tag, input bit stop_mid);
        int unsigned ir;
        int unsigned tick_at;
        int unsigned t0;
        int unsigned stop_at;
        bit          got;
        s_src  = $urandom();
        s_fire = 1'b1;
        step();
        s_fire  = 1'b0;
        ir      = cyc;
        t0      = tick_pulses;
        got     = 1'b0;
        tick_at = 0;
        stop_at = ir + 1 + (SNAP ? 2 : 0);
        exp_push(3'd0, 16'h0, ir + 1);
        if (SNAP) exp_push(3'd4, 16'h0, ir + 2);
        for (int n = 0; n < 12; n++) begin
            step();
            cfg_stop = stop_mid && (cyc == stop_at);
            if (cfg_stop)
                chk({tag, "/stop_state"}, 64'({chipselect, write_n, address}),
                    SNAP ? 64'({1'b1, 1'b1, 3'd4}) : 64'({1'b1, 1'b0, 3'd0}));
            if (tick && !got) begin
                got     = 1'b1;
                tick_at = cyc;
            end
        end
        cfg_stop = 1'b0;
        m_count  = m_count + 32'd1;
        m_snap   = SNAP ? s_src : 32'h0;
        chk({tag, "/tick_cycle"}, 64'(tick_at), 64'(ir + SVC));
        chk({tag, "/tick_pulses"}, 64'(tick_pulses - t0), 64'(1));
        chk({tag, "/tick_count"}, 64'(tick_count), 64'(m_count));
        chk({tag, "/snapshot"}, 64'(snapshot), 64'(m_snap));
        chk({tag, "/irq_cleared"}, 64'(irq), 64'(0));
        if (stop_mid) begin
            exp_push(3'd1, 16'h0008, ir + SVC + 2);
            chk({tag, "/running"}, 64'(running), 64'(0));
        end else begin
            chk({tag, "/running"}, 64'(running), 64'(1));
        end
        chk({tag, "/busy"}, 64'(busy), 64'(0));
        cmp_bus(tag);
    endtask

    task automatic do_stop(input string tag);
        cfg_stop = 1'b1;
        step();
        cfg_stop = 1'b0;
        exp_push(3'd1, 16'h0008, ANY);
        step(8);
        chk({tag, "/running"},    64'(running),    64'(0));
        chk({tag, "/busy"},       64'(busy),       64'(0));
        chk({tag, "/tick_count"}, 64'(tick_count), 64'(m_count));
        chk({tag, "/snapshot"},   64'(snapshot),   64'(m_snap));
        cmp_bus(tag);
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] pe;
        int unsigned c0;

        reset_n = 1'b0;
        step(3);
        chk_reset("reset");
        reset_n = 1'b1;
        step();

        do_start(32'h0001_2C00, 1'b0, "start");
        do_irq("irq1", 1'b0);
        do_irq("irq2", 1'b0);

        cfg_period = 32'd5;
        cfg_start  = 1'b1;
        step();
        cfg_start = 1'b0;
        step(4);
        chk("start_ignored/running", 64'(running), 64'(1));
        cmp_bus("start_ignored");
        do_stop("stop1");

        do_start(32'd3, 1'b0, "clamp");

        force dut.r_tick_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_tick_count;
        m_count = 32'hFFFF_FFFF;
        chk("force/tick_count", 64'(tick_count), 64'(m_count));
        step();
        do_irq("wrap", 1'b0);
        do_irq("stop_mid", 1'b1);

        do_start($urandom(), 1'b1, "start_stop");
        step(6);
        chk("start_stop/running", 64'(running), 64'(1));
        cmp_bus("start_stop_nostop");
        do_irq("irq3", 1'b0);
        do_stop("stop2");

        for (int it = 0; it < 4; it++) begin
            p = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 12)) : 32'($urandom());
            do_start(p, 1'b0, $sformatf("rnd%0d_start", it));
            repeat ($urandom_range(1, 3)) begin
                step($urandom_range(1, 5));
                do_irq($sformatf("rnd%0d_irq", it), 1'b0);
            end
            do_stop($sformatf("rnd%0d_stop", it));
        end

        // Reset in the middle of the period-high write.
        c0 = cyc;
        p  = $urandom();
        pe = (p < MIN_P) ? 32'(MIN_P) : p;
        cfg_period = p;
        cfg_start  = 1'b1;
        exp_push(3'd2, pe[15:0], c0 + 1);
        step();
        cfg_start = 1'b0;
        step();
        chk("rst_mid/wr_ph", 64'({chipselect, write_n, address, writedata}),
            64'({1'b1, 1'b0, 3'd3, pe[31:16]}));
        reset_n = 1'b0;
        #1;
        m_count = 32'h0;
        m_snap  = 32'h0;
        chk_reset("rst_mid");
        step(2);
        cmp_bus("rst_mid");
        reset_n = 1'b1;
        step();

        do_start($urandom(), 1'b0, "restart");
        do_irq("after_rst", 1'b0);
        do_stop("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
